// File: rtl/emaxi_write.sv
// emesh write packet to AXI3 write initiator (AW + one/two W beats + B collection).
// Latency: AW and W valid one cycle after accept; back-to-back 2 cycles single, 3 cycles double.
// Backpressure: wr_wait while a packet is in flight or MAX_OUT AWs await their B response.
module emaxi_write #(
  parameter logic [11:0] ID      = 12'h000,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_access,
  input  logic [103:0] wr_packet,
  output logic         wr_wait,
  output logic [11:0]  m_axi_awid,
  output logic [31:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic [1:0]   m_axi_awburst,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [11:0]  m_axi_wid,
  output logic [31:0]  m_axi_wdata,
  output logic [3:0]   m_axi_wstrb,
  output logic         m_axi_wlast,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [11:0]  m_axi_bid,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic         err,
  output logic [3:0]   outstanding
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

  state_t      state, state_nxt;
  logic        aw_pend, w_pend, beat;
  logic [31:0] h_dst, h_data, h_src;
  logic [1:0]  h_mode;
  logic [3:0]  out_cnt;
  logic        err_q, bready_q;
  logic        busy, accept, is_write, load;
  logic        aw_hs, w_hs, b_hs, aw_done, w_done;

  // B id and ctrlmode carry nothing this block acts on
  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, wr_packet[7:3]};

  assign busy        = (state == S_SEND);
  assign wr_wait     = busy | (out_cnt == MAX_OUT_W);
  assign accept      = wr_access & ~wr_wait;
  assign is_write    = wr_packet[0];
  assign load        = accept & is_write;
  assign aw_hs       = m_axi_awvalid & m_axi_awready;
  assign w_hs        = m_axi_wvalid & m_axi_wready;
  assign b_hs        = m_axi_bvalid & bready_q;
  assign aw_done     = ~aw_pend | aw_hs;
  assign w_done      = ~w_pend | (w_hs & m_axi_wlast);
  assign outstanding = out_cnt;
  assign err         = err_q;
  assign m_axi_bready = bready_q;
  assign m_axi_awid  = ID;
  assign m_axi_wid   = ID;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave SEND once both channels have finished, counting handshakes this cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (load) state_nxt = S_SEND;
      S_SEND: if (aw_done && w_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-channel pending flags and beat index; AW and W retire independently
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      beat    <= 1'b0;
    end else if (state == S_IDLE && load) begin
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
      beat    <= 1'b0;
    end else begin
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs) begin
        if (m_axi_wlast) w_pend <= 1'b0;
        else             beat   <= 1'b1;
      end
    end
  end

  // Holding register, loaded only for write packets
  always_ff @(posedge clk) begin
    if (rst) begin
      h_dst  <= '0;
      h_data <= '0;
      h_src  <= '0;
      h_mode <= '0;
    end else if (load) begin
      h_dst  <= wr_packet[39:8];
      h_data <= wr_packet[71:40];
      h_src  <= wr_packet[103:72];
      h_mode <= wr_packet[2:1];
    end
  end

  // Outstanding AW count, sticky error and B ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt  <= '0;
      err_q    <= 1'b0;
      bready_q <= 1'b0;
    end else begin
      bready_q <= 1'b1;
      if ((accept && !is_write) || (b_hs && (m_axi_bresp != 2'b00 || out_cnt == 4'd0)))
        err_q <= 1'b1;
      if (aw_hs && !b_hs)
        out_cnt <= out_cnt + 4'd1;
      else if (b_hs && !aw_hs && out_cnt != 4'd0)
        out_cnt <= out_cnt - 4'd1;
    end
  end

  // AXI outputs: zero while idle, otherwise mapped from the held packet and beat index
  always_comb begin
    m_axi_awvalid = busy & aw_pend;
    m_axi_wvalid  = busy & w_pend;
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_awsize  = '0;
    m_axi_awburst = '0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    if (busy) begin
      m_axi_awburst = 2'b01;
      m_axi_awaddr  = h_dst;
      m_axi_awsize  = {1'b0, h_mode};
      m_axi_wlast   = 1'b1;
      m_axi_wstrb   = 4'hF;
      m_axi_wdata   = h_data;
      case (h_mode)
        2'd0: begin
          m_axi_wdata = {4{h_data[7:0]}};
          m_axi_wstrb = 4'b0001 << h_dst[1:0];
        end
        2'd1: begin
          m_axi_wdata = {2{h_data[15:0]}};
          m_axi_wstrb = 4'b0011 << {h_dst[1], 1'b0};
        end
        2'd3: begin
          m_axi_awaddr = {h_dst[31:3], 3'b000};
          m_axi_awsize = 3'd2;
          m_axi_awlen  = 8'd1;
          m_axi_wdata  = beat ? h_src : h_data;
          m_axi_wlast  = beat;
        end
        default: ;
      endcase
    end
  end

endmodule
